// File: rtl/arb_pkg.sv
// Shared constants and the per-channel state type for the 8-input requester agent.
package arb_pkg;

    localparam int N_REQ        = 8;
    localparam int LEN_W_DEF    = 4;
    localparam int WAIT_W_DEF   = 8;
    localparam int WAIT_MAX_DEF = 200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } arb_chan_state_e;

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: job accept, burst beat counting, starvation watchdog, sticky starve flag.
module arb_req_chan
    import arb_pkg::*;
#(
    parameter int LEN_W    = LEN_W_DEF,
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            job_valid_i,
    input  logic [LEN_W-1:0] job_len_i,
    input  logic            grant_i,
    input  logic            starve_clr_i,
    output logic            job_ready_o,
    output logic            req_o,
    output logic            done_o,
    output logic            starve_o,
    output arb_chan_state_e state_o
);

    localparam int BEAT_W = LEN_W + 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    arb_chan_state_e   state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              done_q, done_d;
    logic              starve_q, starve_d;
    logic              starve_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
            done_q   <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            done_q   <= done_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        done_d     = 1'b0;
        starve_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (job_valid_i) begin
                    len_d   = job_len_i;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (grant_i) begin
                    beat_d = BEAT_W'(1);
                    wait_d = '0;
                    if (len_q == '0) begin
                        done_d  = 1'b1;
                        state_d = GAP;
                    end else begin
                        state_d = BURST;
                    end
                end else if (wait_q != WAIT_LIM) begin
                    // Starve is an event on reaching the limit, so a later clear sticks.
                    wait_d     = wait_q + WAIT_W'(1);
                    starve_set = (wait_q == WAIT_LIM - WAIT_W'(1));
                end
            end
            BURST: begin
                if (grant_i) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(len_q)) begin
                        done_d  = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        starve_d = starve_set ? 1'b1 : (starve_clr_i ? 1'b0 : starve_q);
    end

    assign req_o       = (state_q == REQ) || (state_q == BURST);
    assign job_ready_o = (state_q == IDLE);
    assign done_o      = done_q;
    assign starve_o    = starve_q;
    assign state_o     = state_q;

endmodule

// File: rtl/arb_req_agent_8.sv
// Requester-side agent: eight channel FSMs driving the arbiter req vector, plus grant protocol checks.
module arb_req_agent_8
    import arb_pkg::*;
#(
    parameter int LEN_W    = LEN_W_DEF,
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       job_valid,
    output logic [N_REQ-1:0]       job_ready,
    input  logic [N_REQ*LEN_W-1:0] job_len,
    output logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       starve,
    input  logic [N_REQ-1:0]       starve_clr,
    output logic                   err_spurious,
    output logic                   err_multi,
    output logic [2*N_REQ-1:0]     dbg_state
);

    arb_chan_state_e chan_state [N_REQ];
    logic            err_spurious_q;
    logic            err_multi_q;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_chan
        arb_req_chan #(
            .LEN_W    (LEN_W),
            .WAIT_W   (WAIT_W),
            .WAIT_MAX (WAIT_MAX)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .job_valid_i  (job_valid[gi]),
            .job_len_i    (job_len[gi*LEN_W +: LEN_W]),
            .grant_i      (grant[gi]),
            .starve_clr_i (starve_clr[gi]),
            .job_ready_o  (job_ready[gi]),
            .req_o        (req[gi]),
            .done_o       (done[gi]),
            .starve_o     (starve[gi]),
            .state_o      (chan_state[gi])
        );
        assign dbg_state[2*gi +: 2] = chan_state[gi];
    end

    // Clearing the lowest set bit leaves something behind only if two or more bits were set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_spurious_q <= 1'b0;
            err_multi_q    <= 1'b0;
        end else begin
            err_spurious_q <= |(grant & ~req);
            err_multi_q    <= |(grant & (grant - N_REQ'(1)));
        end
    end

    assign err_spurious = err_spurious_q;
    assign err_multi    = err_multi_q;

endmodule

// File: tb/tb_arb_req_agent_8.sv
// Bench for arb_req_agent_8: fixed vector table, directed multi-cycle sequences, randomized traffic vs a job-level model.
module tb_arb_req_agent_8;

    localparam int N    = 8;
    localparam int LW   = 4;
    localparam int WMAX = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  job_valid, job_ready, req, grant, done, starve, starve_clr;
    logic [N*LW-1:0] job_len;
    logic          err_spurious, err_multi;
    logic [2*N-1:0] dbg_state;

    arb_req_agent_8 dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_len      (job_len),
        .req          (req),
        .grant        (grant),
        .done         (done),
        .starve       (starve),
        .starve_clr   (starve_clr),
        .err_spurious (err_spurious),
        .err_multi    (err_multi),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Job-level reference: a channel either holds a job with some beats left, sits out one
    // cooldown cycle after finishing, or is free.
    bit m_active [N];
    bit m_gap    [N];
    int m_left   [N];
    int m_granted[N];
    int m_waited [N];
    bit m_starve [N];
    bit m_done   [N];
    bit m_esp, m_emu;

    function automatic logic [N-1:0] m_req_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_active[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 0; m_gap[i] = 0; m_left[i] = 0; m_granted[i] = 0;
            m_waited[i] = 0; m_starve[i] = 0; m_done[i] = 0;
        end
        m_esp = 0; m_emu = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] rq;
        int cnt;
        rq  = m_req_vec();
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(grant[i]);
        m_esp = |(grant & ~rq);
        m_emu = (cnt > 1);
        for (int i = 0; i < N; i++) begin
            bit ready, set_ev;
            ready  = !m_active[i] && !m_gap[i];
            set_ev = 0;
            m_done[i] = 0;
            if (m_gap[i]) begin
                m_gap[i] = 0;
            end else if (ready && job_valid[i]) begin
                m_active[i]  = 1;
                m_left[i]    = int'(job_len[i*LW +: LW]) + 1;
                m_granted[i] = 0;
                m_waited[i]  = 0;
            end else if (m_active[i]) begin
                if (grant[i]) begin
                    m_left[i]--;
                    m_granted[i]++;
                    if (m_left[i] == 0) begin
                        m_active[i] = 0; m_gap[i] = 1; m_done[i] = 1;
                    end
                end else if (m_granted[i] == 0 && m_waited[i] < WMAX) begin
                    m_waited[i]++;
                    if (m_waited[i] == WMAX) set_ev = 1;
                end
            end
            if (set_ev) m_starve[i] = 1;
            else if (starve_clr[i]) m_starve[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] e_req, e_rdy, e_done, e_st;
        for (int i = 0; i < N; i++) begin
            e_req[i]  = m_active[i];
            e_rdy[i]  = !m_active[i] && !m_gap[i];
            e_done[i] = m_done[i];
            e_st[i]   = m_starve[i];
        end
        chk({tag, " req"}, 32'(req), 32'(e_req));
        chk({tag, " job_ready"}, 32'(job_ready), 32'(e_rdy));
        chk({tag, " done"}, 32'(done), 32'(e_done));
        chk({tag, " starve"}, 32'(starve), 32'(e_st));
        chk({tag, " err_spurious"}, 32'(err_spurious), 32'(m_esp));
        chk({tag, " err_multi"}, 32'(err_multi), 32'(m_emu));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        job_valid = '0; job_len = '0; grant = '0; starve_clr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("after_reset");
    endtask

    typedef struct {
        logic [N-1:0]    jv;
        logic [N*LW-1:0] len;
        logic [N-1:0]    gnt;
        logic [N-1:0]    e_req;
        logic [N-1:0]    e_rdy;
        logic [N-1:0]    e_done;
        logic            e_sp;
        logic            e_mu;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dones, errs, rr;
        logic [N-1:0] g;
        int cands[$];

        tbl[0]  = '{8'h04, 32'h0,         8'h00, 8'h04, 8'hFB, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'h00, 32'h0,         8'h04, 8'h00, 8'hFB, 8'h04, 1'b0, 1'b0};
        tbl[2]  = '{8'h00, 32'h0,         8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{8'h00, 32'h0,         8'h01, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{8'h00, 32'h0,         8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{8'h11, 32'h0001_0001, 8'h00, 8'h11, 8'hEE, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{8'h00, 32'h0,         8'h11, 8'h11, 8'hEE, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{8'h00, 32'h0,         8'h01, 8'h10, 8'hEE, 8'h01, 1'b0, 1'b0};
        tbl[8]  = '{8'h00, 32'h0,         8'h10, 8'h00, 8'hEF, 8'h10, 1'b0, 1'b0};
        tbl[9]  = '{8'h00, 32'h0,         8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{8'h02, 32'h0,         8'h00, 8'h02, 8'hFD, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{8'h02, 32'h0,         8'h02, 8'h00, 8'hFD, 8'h02, 1'b0, 1'b0};
        tbl[12] = '{8'h02, 32'h0,         8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[13] = '{8'h00, 32'h0,         8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};

        do_reset();

        for (int r = 0; r < 14; r++) begin
            job_valid = tbl[r].jv;
            job_len   = tbl[r].len;
            grant     = tbl[r].gnt;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d req", r), 32'(req), 32'(tbl[r].e_req));
            chk($sformatf("tbl%0d job_ready", r), 32'(job_ready), 32'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d done", r), 32'(done), 32'(tbl[r].e_done));
            chk($sformatf("tbl%0d err_spurious", r), 32'(err_spurious), 32'(tbl[r].e_sp));
            chk($sformatf("tbl%0d err_multi", r), 32'(err_multi), 32'(tbl[r].e_mu));
        end

        // Channel 5, four beats with holes in the grant pattern.
        do_reset();
        job_valid = 8'h20;
        job_len   = 32'(3) << 20;
        step("ch5_accept");
        job_valid = '0;
        for (int c = 1; c <= 6; c++) begin
            grant = (c == 1 || c == 2 || c == 4 || c == 6) ? 8'h20 : 8'h00;
            step($sformatf("ch5_c%0d", c));
            if (c == 4) chk("ch5 no_done_after_3_grants", 32'(done[5]), 32'd0);
            if (c == 6) chk("ch5 done_after_4th_grant", 32'(done[5]), 32'd1);
        end
        grant = '0;
        step("ch5_gap");
        step("ch5_idle");
        chk("ch5 ready_again", 32'(job_ready[5]), 32'd1);
        chk("ch5 no_starve", 32'(starve[5]), 32'd0);

        // All channels, two beats each, single rotating grant.
        job_valid = 8'hFF;
        job_len   = 32'h1111_1111;
        step("rr_accept");
        job_valid = '0;
        job_len   = '0;
        dones = 0; errs = 0; rr = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            logic [N-1:0] rq;
            bit found;
            rq = m_req_vec();
            g = '0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (rr + k) % N;
                if (!found && rq[idx]) begin
                    g[idx] = 1'b1;
                    rr = idx + 1;
                    found = 1;
                end
            end
            grant = g;
            step("rr");
            dones += $countones(done);
            errs  += int'(err_spurious) + int'(err_multi);
        end
        grant = '0;
        chk("rr done_count", 32'(dones), 32'd8);
        chk("rr req_all_low", 32'(req), 32'd0);
        chk("rr err_count", 32'(errs), 32'd0);

        // Starvation watchdog on channel 0.
        job_valid = 8'h01;
        step("st_accept");
        job_valid = '0;
        for (int k = 1; k <= WMAX + 5; k++) begin
            step("st_wait");
            if (k == WMAX - 1) chk("st starve_before_limit", 32'(starve[0]), 32'd0);
            if (k == WMAX) chk("st starve_at_limit", 32'(starve[0]), 32'd1);
        end
        chk("st starve_sticky", 32'(starve[0]), 32'd1);
        starve_clr = 8'h01;
        step("st_clr");
        chk("st cleared", 32'(starve[0]), 32'd0);
        starve_clr = '0;
        grant = 8'h01;
        step("st_grant");
        grant = '0;
        step("st_gap");
        step("st_idle");
        job_valid = 8'h01;
        step("st_accept2");
        job_valid = '0;
        for (int k = 1; k < WMAX; k++) step("st_wait2");
        starve_clr = 8'h01;
        step("st_set_vs_clr");
        chk("st set_wins_over_clr", 32'(starve[0]), 32'd1);
        starve_clr = '0;
        grant = 8'h01;
        step("st_grant2");
        grant = '0;
        step("st_gap2");
        starve_clr = 8'h01;
        step("st_clr_idle");
        starve_clr = '0;
        step("st_clr_idle2");

        // Reset in the middle of a four-beat burst on channel 3.
        job_valid = 8'h08;
        job_len   = 32'(3) << 12;
        step("rb_accept");
        job_valid = '0;
        grant = 8'h08;
        step("rb_beat1");
        step("rb_beat2");
        grant = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("rb req3_drops_async", 32'(req[3]), 32'd0);
        chk("rb done_low_in_reset", 32'(done), 32'd0);
        chk("rb ready_in_reset", 32'(job_ready), 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step("rb_post1");
        step("rb_post2");
        job_valid = 8'h08;
        step("rb_newjob");
        chk("rb req3_new_job", 32'(req[3]), 32'd1);
        job_valid = '0;
        grant = 8'h08;
        for (int k = 0; k < 4; k++) step("rb_newburst");
        grant = '0;
        step("rb_tail");

        // Random traffic; second phase never serves channel 6 so its watchdog fires.
        for (int ph = 0; ph < 2; ph++) begin
            logic [N-1:0] mask;
            mask = (ph == 0) ? 8'hFF : 8'hBF;
            for (int cyc = 0; cyc < ((ph == 0) ? 400 : 300); cyc++) begin
                int sel;
                job_valid  = N'($urandom);
                job_len    = $urandom;
                starve_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) & mask : '0;
                sel = $urandom_range(0, 9);
                cands.delete();
                for (int i = 0; i < N; i++) if (m_req_vec()[i] && mask[i]) cands.push_back(i);
                g = '0;
                if (sel <= 5 && cands.size() > 0) g[cands[$urandom_range(0, cands.size() - 1)]] = 1'b1;
                else if (sel == 8) g = N'($urandom) & mask;
                else if (sel == 9 && cands.size() > 1) begin
                    g[cands[0]] = 1'b1;
                    g[cands[cands.size() - 1]] = 1'b1;
                end
                grant = g;
                step($sformatf("rnd_p%0d", ph));
            end
        end
        clear_inputs();
        step("rnd_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
